// File: rtl/led_pkg.sv
// led_pkg: shared encodings for the LED pattern sequencer.
// Mode codes, per-mode seed patterns and bounce direction values.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_RUN1   = 2'd0,
      MODE_RUN2   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_t;

   localparam logic [7:0] SEED_RUN1   = 8'h01;
   localparam logic [7:0] SEED_RUN2   = 8'h03;
   localparam logic [7:0] SEED_BOUNCE = 8'h01;
   localparam logic [7:0] SEED_FILL   = 8'h00;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic logic [7:0] seed_of(input mode_t m);
      logic [7:0] s;
      s = SEED_RUN1;
      unique case (m)
         MODE_RUN1:   s = SEED_RUN1;
         MODE_RUN2:   s = SEED_RUN2;
         MODE_BOUNCE: s = SEED_BOUNCE;
         MODE_FILL:   s = SEED_FILL;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: programmable prescaler producing the pattern step tick.
// Ports: clk, rs (sync high reset), en, speed[1:0] in; tick out (comb).
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rs,
   input  logic       en,
   input  logic [1:0] speed,
   output logic       tick
);

   localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last;
   logic             w_tick;

   // >= rather than == so a mid-count speed-up ticks at once
   // instead of wrapping the whole counter.
   assign w_last = (DIV >> speed) - CNT_W'(1);
   assign w_tick = en && (r_cnt >= w_last);
   assign tick   = w_tick;

   always_ff @(posedge clk) begin
      if (rs) begin
         r_cnt <= '0;
      end else if (!en || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED pattern sequencer (RUN1, RUN2, BOUNCE, FILL).
// Ports: clk, rs, en, mode[1:0], dir, speed[1:0] in; led[7:0], step out.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rs,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       dir,
   input  logic [1:0] speed,
   output logic [7:0] led,
   output logic       step
);

   logic [7:0] r_led;
   mode_t      r_mode;
   logic       r_bdir;
   logic       r_step;

   logic       w_tick;
   mode_t      w_mode_in;
   logic [7:0] w_led_nxt;
   mode_t      w_mode_nxt;
   logic       w_bdir_nxt;
   logic       w_step_nxt;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_tick (
      .clk   (clk),
      .rs    (rs),
      .en    (en),
      .speed (speed),
      .tick  (w_tick)
   );

   assign w_mode_in = mode_t'(mode);

   always_comb begin
      w_led_nxt  = r_led;
      w_mode_nxt = r_mode;
      w_bdir_nxt = r_bdir;
      w_step_nxt = 1'b0;
      if (w_tick) begin
         w_step_nxt = 1'b1;
         if (w_mode_in != r_mode) begin
            // mode switch only reseeds; the first advance is next tick
            w_mode_nxt = w_mode_in;
            w_led_nxt  = seed_of(w_mode_in);
            w_bdir_nxt = DIR_LEFT;
         end else begin
            unique case (r_mode)
               MODE_RUN1, MODE_RUN2: begin
                  if (dir == DIR_LEFT)
                     w_led_nxt = {r_led[6:0], r_led[7]};
                  else
                     w_led_nxt = {r_led[0], r_led[7:1]};
               end
               MODE_BOUNCE: begin
                  if (r_bdir == DIR_LEFT) begin
                     if (r_led[7]) begin
                        w_bdir_nxt = DIR_RIGHT;
                        w_led_nxt  = r_led >> 1;
                     end else begin
                        w_led_nxt  = r_led << 1;
                     end
                  end else begin
                     if (r_led[0]) begin
                        w_bdir_nxt = DIR_LEFT;
                        w_led_nxt  = r_led << 1;
                     end else begin
                        w_led_nxt  = r_led >> 1;
                     end
                  end
               end
               MODE_FILL: begin
                  if (r_led == 8'hFF)
                     w_led_nxt = 8'h00;
                  else if (dir == DIR_LEFT)
                     w_led_nxt = {r_led[6:0], 1'b1};
                  else
                     w_led_nxt = {1'b1, r_led[7:1]};
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rs) begin
         r_led  <= SEED_RUN1;
         r_mode <= MODE_RUN1;
         r_bdir <= DIR_LEFT;
         r_step <= 1'b0;
      end else begin
         r_led  <= w_led_nxt;
         r_mode <= w_mode_nxt;
         r_bdir <= w_bdir_nxt;
         r_step <= w_step_nxt;
      end
   end

   assign led  = r_led;
   assign step = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed bench for led_pattern_ctrl, TICK_DIV=8.
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_led_pattern_ctrl;

   logic       clk;
   logic       rs;
   logic       en;
   logic [1:0] mode;
   logic       dir;
   logic [1:0] speed;
   logic [7:0] led;
   logic       step;

   int n_cmp;
   int n_bad;

   led_pattern_ctrl #(
      .TICK_DIV (8),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .rs    (rs),
      .en    (en),
      .mode  (mode),
      .dir   (dir),
      .speed (speed),
      .led   (led),
      .step  (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance edge by edge until step is seen or the budget runs out
   task automatic wait_step(input int max, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!step && cyc < max);
      if (!step) cyc = -1;
   endtask

   task automatic test_reset_run1;
      logic [7:0] exp_seq [8];
      int         cyc;
      exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10,
                  8'h20, 8'h40, 8'h80, 8'h01};
      rs = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0; speed = 2'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rs = 1'b0;
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: led=%h step=%b want led=01 step=0",
                  led, step);
      end
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_step(20, cyc);
         n_cmp++;
         if (cyc !== 8 || led !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL run1_left[%0d]: led=%h cyc=%0d want %h/8",
                     i, led, cyc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_speed_enable;
      logic [7:0] exp_fast [3];
      logic [7:0] held;
      int         cyc;
      int         bad;
      exp_fast = '{8'h02, 8'h04, 8'h08};
      speed = 2'd3;
      for (int i = 0; i < 3; i++) begin
         wait_step(20, cyc);
         n_cmp++;
         if (cyc !== 1 || led !== exp_fast[i]) begin
            n_bad++;
            $display("FAIL speed3[%0d]: led=%h cyc=%0d want %h/1",
                     i, led, cyc, exp_fast[i]);
         end
      end
      speed = 2'd0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (step !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL speed0_count: step seen %0d times want 0", bad);
      end
      speed = 2'd2;
      wait_step(20, cyc);
      n_cmp++;
      if (cyc !== 1 || led !== 8'h10) begin
         n_bad++;
         $display("FAIL speed_drop: led=%h cyc=%0d want 10/1", led, cyc);
      end
      wait_step(20, cyc);
      n_cmp++;
      if (cyc !== 2 || led !== 8'h20) begin
         n_bad++;
         $display("FAIL speed2: led=%h cyc=%0d want 20/2", led, cyc);
      end
      en = 1'b0;
      held = 8'h20;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (step !== 1'b0 || led !== held) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL en_freeze: %0d bad cycles led=%h want 20", bad, led);
      end
      en = 1'b1;
      speed = 2'd0;
      wait_step(20, cyc);
      n_cmp++;
      if (cyc !== 8 || led !== 8'h40) begin
         n_bad++;
         $display("FAIL en_resume: led=%h cyc=%0d want 40/8", led, cyc);
      end
   endtask

   task automatic test_run2_right;
      logic [7:0] exp_seq [4];
      int         cyc;
      exp_seq = '{8'h03, 8'h81, 8'hC0, 8'h60};
      mode = 2'd1; dir = 1'b1; speed = 2'd3;
      for (int i = 0; i < 4; i++) begin
         wait_step(20, cyc);
         n_cmp++;
         if (cyc !== 1 || led !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL run2_right[%0d]: led=%h cyc=%0d want %h/1",
                     i, led, cyc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_bounce;
      logic [7:0] exp_seq [16];
      int         cyc;
      exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      mode = 2'd2; speed = 2'd3;
      for (int i = 0; i < 16; i++) begin
         dir = ~dir;
         wait_step(20, cyc);
         n_cmp++;
         if (cyc !== 1 || led !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL bounce[%0d]: led=%h cyc=%0d want %h/1",
                     i, led, cyc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      mode = 2'd3; speed = 2'd3;
      wait_step(20, cyc);
      mode = 2'd2;
      for (int i = 0; i < 7; i++) wait_step(20, cyc);
      n_cmp++;
      if (led !== 8'h40) begin
         n_bad++;
         $display("FAIL mid_setup: led=%h want 40", led);
      end
      rs = 1'b1;
      @(posedge clk); #1;
      rs = 1'b0;
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: led=%h step=%b want 01/0", led, step);
      end
      wait_step(20, cyc);
      n_cmp++;
      if (cyc !== 1 || led !== 8'h01) begin
         n_bad++;
         $display("FAIL mid_reseed: led=%h cyc=%0d want 01/1", led, cyc);
      end
      wait_step(20, cyc);
      n_cmp++;
      if (cyc !== 1 || led !== 8'h02) begin
         n_bad++;
         $display("FAIL mid_bounce: led=%h cyc=%0d want 02/1", led, cyc);
      end
   endtask

   task automatic test_fill;
      logic [7:0] exp_seq [14];
      int         cyc;
      exp_seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F,
                  8'h7F, 8'hFF, 8'h00, 8'h01, 8'h03, 8'h07, 8'h83};
      mode = 2'd3; dir = 1'b0; speed = 2'd3;
      for (int i = 0; i < 14; i++) begin
         if (i == 13) dir = 1'b1;
         wait_step(20, cyc);
         n_cmp++;
         if (cyc !== 1 || led !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL fill[%0d]: led=%h cyc=%0d want %h/1",
                     i, led, cyc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_reset_vs_mode;
      mode = 2'd1; rs = 1'b1;
      @(posedge clk); #1;
      rs = 1'b0; en = 1'b0;
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_vs_mode: led=%h step=%b want 01/0", led, step);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rs = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0; speed = 2'd0;
      test_reset_run1();
      test_speed_enable();
      test_run2_right();
      test_bounce();
      test_reset_mid_run();
      test_fill();
      test_reset_vs_mode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
